// File: rtl/icache_dcache_mem_arbiter.sv
// Arbitrates the shared block-wide memory port between I-cache refills and
// D-cache refills/writebacks: round-robin, one access in flight at a time.
module icache_dcache_mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t            state_q;
  logic              owner_q;
  logic              last_owner_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_writedata_q;
  logic [DATA_W-1:0] i_readdata_q;
  logic [DATA_W-1:0] d_readdata_q;

  logic i_pend;
  logic d_pend;
  logic owner_d;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;

  // On a tie the requester that did not win last time gets the port.
  assign owner_d = d_pend & (~i_pend | (last_owner_q == OWN_I));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      owner_q         <= OWN_I;
      last_owner_q    <= OWN_I;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      i_readdata_q    <= '0;
      d_readdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_pend | d_pend) begin
            owner_q <= owner_d;
            state_q <= REQ;
            if (owner_d == OWN_D) begin
              mem_address_q <= d_address;
              if (d_write) begin
                mem_write_q     <= 1'b1;
                mem_writedata_q <= d_writedata;
              end else begin
                mem_read_q <= 1'b1;
              end
            end else begin
              mem_address_q <= i_address;
              mem_read_q    <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_busywait) state_q <= WAIT;
        end
        WAIT: begin
          if (!mem_busywait) begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            last_owner_q <= owner_q;
            state_q      <= DONE;
            if (mem_read_q) begin
              if (owner_q == OWN_D) d_readdata_q <= mem_readdata;
              else                  i_readdata_q <= mem_readdata;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall every pending requester except the owner during its completion cycle.
  assign i_busywait = ~reset & i_pend & ~((state_q == DONE) & (owner_q == OWN_I));
  assign d_busywait = ~reset & d_pend & ~((state_q == DONE) & (owner_q == OWN_D));

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;
  assign i_readdata    = i_readdata_q;
  assign d_readdata    = d_readdata_q;

endmodule

// File: tb/tb_icache_dcache_mem_arbiter.sv
// Bench for icache_dcache_mem_arbiter: a latency-configurable memory, a
// transaction-level reference model, and directed plus randomized requesters.
module tb_icache_dcache_mem_arbiter;

  logic         clock;
  logic         reset;
  logic         i_read;
  logic [27:0]  i_address;
  logic [127:0] i_readdata;
  logic         i_busywait;
  logic         d_read;
  logic         d_write;
  logic [27:0]  d_address;
  logic [127:0] d_writedata;
  logic [127:0] d_readdata;
  logic         d_busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  icache_dcache_mem_arbiter #(.ADDR_W(28), .DATA_W(128)) dut (
    .clock        (clock),
    .reset        (reset),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_readdata   (i_readdata),
    .i_busywait   (i_busywait),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_writedata  (d_writedata),
    .d_readdata   (d_readdata),
    .d_busywait   (d_busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Default block content of every address.
  function automatic logic [127:0] fblk(input logic [27:0] a);
    return {4{32'h3e800093 ^ {4'h0, a}}};
  endfunction

  // Memory: busywait rises the cycle after a strobe, stays high mem_lat cycles,
  // then waits for the strobe to drop before accepting another access.
  int           mem_lat = 4;
  logic         m_busy, m_rel, m_wr;
  int           m_cnt;
  logic [27:0]  m_addr;
  logic [127:0] m_wd;
  logic [255:0] m_wv;
  logic [127:0] mstore [256];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy       <= 1'b0;
      m_rel        <= 1'b0;
      m_wr         <= 1'b0;
      m_cnt        <= 0;
      m_addr       <= '0;
      m_wd         <= '0;
      m_wv         <= '0;
      mem_busywait <= 1'b0;
      mem_readdata <= '0;
    end else begin
      if (!m_busy && !m_rel && (mem_read || mem_write)) begin
        m_busy       <= 1'b1;
        mem_busywait <= 1'b1;
        m_cnt        <= mem_lat - 1;
        m_wr         <= mem_write;
        m_addr       <= mem_address;
        m_wd         <= mem_writedata;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy       <= 1'b0;
          mem_busywait <= 1'b0;
          m_rel        <= 1'b1;
          if (m_wr) begin
            mstore[m_addr[7:0]] <= m_wd;
            m_wv[m_addr[7:0]]   <= 1'b1;
          end else begin
            mem_readdata <= m_wv[m_addr[7:0]] ? mstore[m_addr[7:0]] : fblk(m_addr);
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (m_rel && !mem_read && !mem_write) m_rel <= 1'b0;
    end
  end

  // Reference model: one access at a time; strobe from grant until the memory
  // has been seen busy and then idle; a one-cycle completion follows.
  logic         md_act, md_seen, md_done, md_own, md_last, md_wr;
  logic [27:0]  md_addr;
  logic [127:0] md_wd, md_ird, md_drd;
  logic [255:0] sh_wv;
  logic [127:0] shadow [256];
  logic         md_pick;
  int           gcnt = 0;
  logic         glog_own  [64];
  logic [27:0]  glog_addr [64];

  // 1 = D-cache wins this grant.
  assign md_pick = (i_read && (d_read || d_write)) ? ~md_last : (d_read || d_write);

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      md_act  <= 1'b0;
      md_seen <= 1'b0;
      md_done <= 1'b0;
      md_own  <= 1'b0;
      md_last <= 1'b0;
      md_wr   <= 1'b0;
      md_addr <= '0;
      md_wd   <= '0;
      md_ird  <= '0;
      md_drd  <= '0;
      sh_wv   <= '0;
    end else if (md_done) begin
      md_done <= 1'b0;
    end else if (!md_act) begin
      if (i_read || d_read || d_write) begin
        md_act  <= 1'b1;
        md_seen <= 1'b0;
        md_own  <= md_pick;
        md_wr   <= md_pick & d_write;
        md_addr <= md_pick ? d_address : i_address;
        if (md_pick && d_write) md_wd <= d_writedata;
        if (gcnt < 64) begin
          glog_own[gcnt[5:0]]  <= md_pick;
          glog_addr[gcnt[5:0]] <= md_pick ? d_address : i_address;
        end
        gcnt <= gcnt + 1;
      end
    end else if (!md_seen) begin
      if (mem_busywait) md_seen <= 1'b1;
    end else if (!mem_busywait) begin
      md_act  <= 1'b0;
      md_done <= 1'b1;
      md_last <= md_own;
      if (md_wr) begin
        shadow[md_addr[7:0]] <= md_wd;
        sh_wv[md_addr[7:0]]  <= 1'b1;
      end else if (md_own) begin
        md_drd <= sh_wv[md_addr[7:0]] ? shadow[md_addr[7:0]] : fblk(md_addr);
      end else begin
        md_ird <= sh_wv[md_addr[7:0]] ? shadow[md_addr[7:0]] : fblk(md_addr);
      end
    end
  end

  int   n_chk  = 0;
  int   n_fail = 0;
  logic ic, dc, mr_seen, mw_seen, mb_seen;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: compare everything mid-cycle, then drop completed requests
  // just after the following posedge.
  task automatic step();
    @(negedge clock);
    chk("mem_read",      128'(mem_read),    128'(md_act & ~md_wr));
    chk("mem_write",     128'(mem_write),   128'(md_act & md_wr));
    chk("mem_address",   128'(mem_address), 128'(md_addr));
    chk("mem_writedata", mem_writedata,     md_wd);
    chk("i_readdata",    i_readdata,        md_ird);
    chk("d_readdata",    d_readdata,        md_drd);
    chk("i_busywait",    128'(i_busywait),  128'(~reset & i_read & ~(md_done & ~md_own)));
    chk("d_busywait",    128'(d_busywait),  128'(~reset & (d_read | d_write) & ~(md_done & md_own)));
    ic      = i_read && !i_busywait && !reset;
    dc      = (d_read || d_write) && !d_busywait && !reset;
    mr_seen = mem_read;
    mw_seen = mem_write;
    mb_seen = mem_busywait;
    @(posedge clock);
    #2;
    if (ic) i_read = 1'b0;
    if (dc) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int  g, lat, gb;
    bit  idn, ddn, first_d, changed, chk1;
    reset = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_writedata = '0;
    ic = 1'b0; dc = 1'b0; mr_seen = 1'b0; mw_seen = 1'b0; mb_seen = 1'b0;
    #1 reset = 1'b1;
    step();
    chk("reset_i_busywait", 128'(i_busywait), 128'(0));
    chk("reset_mem_read",   128'(mem_read),   128'(0));
    step();
    reset = 1'b0;

    // Lone I-cache read with a 16-cycle memory.
    mem_lat = 16; i_address = 28'h0; i_read = 1'b1;
    g = -1; lat = -1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (g < 0 && mr_seen) g = k;
      if (ic) begin lat = k - g; break; end
    end
    chk("t1_latency", 128'(lat), 128'(18));
    chk("t1_i_readdata", i_readdata, {4{32'h3e800093}});
    chk("t1_d_readdata", d_readdata, 128'(0));
    repeat (2) step();

    // Lone D-cache writeback.
    mem_lat = 4; d_address = 28'h5; d_writedata = {16{8'hA5}}; d_write = 1'b1;
    chk1 = 1'b0; ddn = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (mw_seen && !chk1) begin
        chk1 = 1'b1;
        chk("t2_mem_address", 128'(mem_address), 128'(5));
        chk("t2_mem_writedata", mem_writedata, {16{8'hA5}});
      end
      if (dc) begin ddn = 1'b1; break; end
    end
    chk("t2_done", 128'(ddn), 128'(1));
    chk("t2_mem_write_dropped", 128'(mem_write), 128'(0));
    chk("t2_d_readdata", d_readdata, 128'(0));
    repeat (2) step();

    // Simultaneous first requests after reset: D wins the tie.
    do_reset();
    mem_lat = 3; gb = gcnt;
    i_address = 28'h10; d_address = 28'h20; i_read = 1'b1; d_read = 1'b1;
    idn = 1'b0; ddn = 1'b0; first_d = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (dc && !idn) first_d = 1'b1;
      if (ic) idn = 1'b1;
      if (dc) ddn = 1'b1;
      if (idn && ddn) break;
    end
    chk("t3_d_first", 128'(first_d), 128'(1));
    chk("t3_grant0_d", 128'(glog_own[gb]), 128'(1));
    chk("t3_grant1_i", 128'(glog_own[gb + 1]), 128'(0));
    chk("t3_i_readdata", i_readdata, fblk(28'h10));
    chk("t3_d_readdata", d_readdata, fblk(28'h20));

    // Continuous requests from both sides: strict alternation.
    mem_lat = 2; gb = gcnt;
    i_address = 28'h11; d_address = 28'hD0; i_read = 1'b1; d_read = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      step();
      if (ic) i_read = 1'b1;
      if (dc) d_read = 1'b1;
      if (gcnt - gb >= 4) break;
    end
    i_read = 1'b0; d_read = 1'b0;
    repeat (30) step();
    for (int n = 0; n < 4; n++) begin
      chk("t4_order", 128'(glog_own[gb + n]), 128'((n % 2) == 0));
      chk("t4_addr", 128'(glog_addr[gb + n]), 128'(((n % 2) == 0) ? 28'hD0 : 28'h11));
    end

    // Address change while the access is in progress is ignored.
    mem_lat = 6; i_address = 28'h1; i_read = 1'b1; changed = 1'b0; idn = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (mb_seen && !changed) begin i_address = 28'h2; changed = 1'b1; end
      if (ic) begin idn = 1'b1; break; end
    end
    chk("t5_done", 128'(idn), 128'(1));
    chk("t5_mem_address", 128'(mem_address), 128'(1));
    chk("t5_i_readdata", i_readdata, fblk(28'h1));
    repeat (2) step();

    // Asynchronous reset in the middle of a memory wait.
    mem_lat = 8; i_address = 28'h3; d_address = 28'h4; i_read = 1'b1; d_read = 1'b1;
    chk1 = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (mb_seen) begin chk1 = 1'b1; break; end
    end
    chk("t6_reached_wait", 128'(chk1), 128'(1));
    #1 reset = 1'b1;
    #1;
    chk("t6_mem_read", 128'(mem_read), 128'(0));
    chk("t6_i_busywait", 128'(i_busywait), 128'(0));
    chk("t6_d_busywait", 128'(d_busywait), 128'(0));
    chk("t6_mem_address", 128'(mem_address), 128'(0));
    d_read = 1'b0;
    step();
    step();
    reset = 1'b0;
    g = -1; lat = -1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (g < 0 && mr_seen) g = k;
      if (ic) begin lat = k - g; break; end
    end
    chk("t6_latency", 128'(lat), 128'(10));
    chk("t6_i_readdata", i_readdata, fblk(28'h3));

    // Randomized traffic with address wiggles and occasional abandoned requests.
    for (int k = 0; k < 1500; k++) begin
      step();
      mem_lat = int'($urandom_range(1, 5));
      if (!i_read) begin
        if ($urandom_range(0, 3) == 0) begin
          i_read = 1'b1;
          i_address = 28'($urandom_range(0, 255));
        end
      end else begin
        if ($urandom_range(0, 7) == 0) i_address = 28'($urandom_range(0, 255));
        if ($urandom_range(0, 99) == 0) i_read = 1'b0;
      end
      if (!(d_read || d_write)) begin
        if ($urandom_range(0, 3) == 0) begin
          int m;
          m = int'($urandom_range(0, 3));
          d_read  = (m == 0) || (m == 2) || (m == 3);
          d_write = (m == 1) || (m == 2);
          d_address = 28'($urandom_range(0, 255));
          d_writedata = {$urandom, $urandom, $urandom, $urandom};
        end
      end else begin
        if ($urandom_range(0, 7) == 0) begin
          d_address = 28'($urandom_range(0, 255));
          d_writedata = {$urandom, $urandom, $urandom, $urandom};
        end
        if ($urandom_range(0, 99) == 0) begin
          d_read = 1'b0;
          d_write = 1'b0;
        end
      end
    end
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (40) step();
    chk("drain_idle_read", 128'(mem_read), 128'(0));
    chk("drain_idle_write", 128'(mem_write), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
